// File: rtl/cbfp_pkg.sv
// Shared types and constants for the CBFP control unit.
package cbfp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_e;

    localparam int unsigned CBFP_BLK_LEN     = 16;
    localparam int unsigned CBFP_NUM_BLK     = 32;
    localparam int unsigned CBFP_ADDR_W      = $clog2(CBFP_BLK_LEN);
    localparam int unsigned CBFP_BLK_W       = $clog2(CBFP_NUM_BLK);
    localparam int unsigned CBFP_MIN_LAT_MAX = CBFP_BLK_LEN - 2;

    // Index width that stays at least 1 bit when the count is 1.
    function automatic int unsigned cbfp_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cu_cbfp_dly.sv
// DEPTH-stage 1-bit shift delay with synchronous reset.
module cu_cbfp_dly
    import cbfp_pkg::*;
#(
    parameter int unsigned DEPTH = 2
)(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    if (DEPTH == 1) begin : g_one
        always_ff @(posedge clk) begin
            if (rst) sr <= '0;
            else     sr <= d;
        end
    end else begin : g_chain
        always_ff @(posedge clk) begin
            if (rst) sr <= '0;
            else     sr <= {sr[DEPTH-2:0], d};
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/cu_cbfp_blk.sv
// CBFP control unit: block/frame counting and ping-pong buffer sequencing.
// Optional readout backpressure is enabled by defining CU_CBFP_BACKPRESSURE_EN.
module cu_cbfp_blk
    import cbfp_pkg::*;
#(
    parameter int unsigned BLK_LEN = CBFP_BLK_LEN,
    parameter int unsigned NUM_BLK = CBFP_NUM_BLK,
    parameter int unsigned MIN_LAT = 2
)(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic                            out_ready,
    output logic                            mag_en,
    output logic [cbfp_width(BLK_LEN)-1:0]  wr_addr,
    output logic                            wr_bank,
    output logic                            min_en,
    output logic                            valid_out,
    output logic [cbfp_width(BLK_LEN)-1:0]  rd_addr,
    output logic                            rd_bank,
    output logic [cbfp_width(NUM_BLK)-1:0]  blk_idx,
    output logic                            frame_done,
    output logic                            overrun
);

    localparam int unsigned AW        = cbfp_width(BLK_LEN);
    localparam int unsigned BW        = cbfp_width(NUM_BLK);
    localparam logic [AW-1:0] ADDR_LAST = AW'(BLK_LEN - 1);
    localparam logic [BW-1:0] BLK_LAST  = BW'(NUM_BLK - 1);
    localparam int unsigned DLY_DEPTH = (MIN_LAT > CBFP_MIN_LAT_MAX) ? CBFP_MIN_LAT_MAX :
                                        ((MIN_LAT < 1) ? 1 : MIN_LAT);

    logic [AW-1:0] wr_cnt;
    logic          wr_bank_ptr;
    logic          blk_end;
    logic          wr_start;
    logic          accept;
    logic          last_beat;
    logic          pending;
    logic [1:0]    bank_busy;
    logic          wr_hits_unread;
    rd_state_e     state;

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_en      <= 1'b0;
            wr_addr     <= '0;
            wr_bank     <= 1'b0;
            wr_cnt      <= '0;
            wr_bank_ptr <= 1'b0;
        end else begin
            mag_en <= in_valid;
            if (in_valid) begin
                wr_addr <= wr_cnt;
                wr_bank <= wr_bank_ptr;
                wr_cnt  <= wr_cnt + 1'b1;
                if (wr_cnt == ADDR_LAST)
                    wr_bank_ptr <= ~wr_bank_ptr;
            end
        end
    end

    assign blk_end  = mag_en && (wr_addr == ADDR_LAST);
    assign wr_start = mag_en && (wr_addr == '0);

    cu_cbfp_dly #(
        .DEPTH (DLY_DEPTH)
    ) u_min_dly (
        .clk (clk),
        .rst (rst),
        .d   (blk_end),
        .q   (min_en)
    );

`ifdef CU_CBFP_BACKPRESSURE_EN
    assign accept = valid_out && out_ready;
`else
    logic unused_out_ready;
    assign unused_out_ready = out_ready;
    assign accept = valid_out;
`endif

    assign last_beat  = accept && (rd_addr == ADDR_LAST);
    assign frame_done = last_beat && (blk_idx == BLK_LAST);

    // rd_addr wraps to 0 on the last beat, so a back-to-back block needs no reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            valid_out <= 1'b0;
            rd_addr   <= '0;
            rd_bank   <= 1'b0;
            blk_idx   <= '0;
            pending   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (min_en || pending) begin
                        state     <= READ;
                        valid_out <= 1'b1;
                        rd_addr   <= '0;
                        pending   <= pending && min_en;
                    end
                end
                READ: begin
                    if (accept)
                        rd_addr <= rd_addr + 1'b1;
                    if (last_beat) begin
                        rd_bank <= ~rd_bank;
                        blk_idx <= (blk_idx == BLK_LAST) ? '0 : blk_idx + 1'b1;
                        if (pending || min_en) begin
                            pending <= pending && min_en;
                        end else begin
                            state     <= IDLE;
                            valid_out <= 1'b0;
                        end
                    end else if (min_en) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

    // A busy bank whose readout is already past address 0 can safely take a new
    // address-0 write; only flag writes that would clobber unread data.
    assign wr_hits_unread = wr_start && bank_busy[wr_bank] &&
                            !((state == READ) && (rd_bank == wr_bank) && (rd_addr != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_busy <= '0;
            overrun   <= 1'b0;
        end else begin
            if (last_beat)
                bank_busy[rd_bank] <= 1'b0;
            if (blk_end)
                bank_busy[wr_bank] <= 1'b1;
            if (wr_hits_unread ||
                (min_en && pending && (state == READ) && !last_beat))
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cu_cbfp_blk.sv
// Directed self-checking bench for cu_cbfp_blk (BLK_LEN=16, NUM_BLK=4, MIN_LAT=2).
module tb_cu_cbfp_blk;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic       mag_en;
    logic [3:0] wr_addr;
    logic       wr_bank;
    logic       min_en;
    logic       valid_out;
    logic [3:0] rd_addr;
    logic       rd_bank;
    logic [1:0] blk_idx;
    logic       frame_done;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cu_cbfp_blk #(
        .BLK_LEN (16),
        .NUM_BLK (4),
        .MIN_LAT (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .out_ready  (out_ready),
        .mag_en     (mag_en),
        .wr_addr    (wr_addr),
        .wr_bank    (wr_bank),
        .min_en     (min_en),
        .valid_out  (valid_out),
        .rd_addr    (rd_addr),
        .rd_bank    (rd_bank),
        .blk_idx    (blk_idx),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Expectations for one 16-sample block written at relative cycles 0..15.
    task automatic chk_single(input string p, input int r);
        chk({p, "_mag_en"}, mag_en, (r >= 1 && r <= 16));
        if (r >= 1 && r <= 16) begin
            chk({p, "_wr_addr"}, wr_addr, r - 1);
            chk({p, "_wr_bank"}, wr_bank, 0);
        end
        chk({p, "_min_en"}, min_en, (r == 18));
        chk({p, "_valid_out"}, valid_out, (r >= 19 && r <= 34));
        if (r >= 19 && r <= 34) begin
            chk({p, "_rd_addr"}, rd_addr, r - 19);
            chk({p, "_rd_bank"}, rd_bank, 0);
            chk({p, "_blk_idx"}, blk_idx, 0);
        end
        chk({p, "_frame_done"}, frame_done, 0);
        chk({p, "_overrun"}, overrun, 0);
        if (r == 0) begin
            chk({p, "_rst_wr_addr"}, wr_addr, 0);
            chk({p, "_rst_wr_bank"}, wr_bank, 0);
            chk({p, "_rst_rd_addr"}, rd_addr, 0);
            chk({p, "_rst_rd_bank"}, rd_bank, 0);
            chk({p, "_rst_blk_idx"}, blk_idx, 0);
        end
        if (r == 39)
            chk({p, "_blk_idx_after"}, blk_idx, 1);
    endtask

    initial begin
        // Test 1: one contiguous block
        do_reset();
        for (int c = 0; c < 40; c++) begin
            in_valid = (c < 16);
            @(negedge clk);
            chk_single("t1", c);
            @(posedge clk); #1;
        end

        // Test 2: in_valid every other cycle
        do_reset();
        for (int c = 0; c < 55; c++) begin
            in_valid = (c < 32) && (c % 2 == 0);
            @(negedge clk);
            chk("t2_mag_en", mag_en, (c <= 31) && (c % 2 == 1));
            if ((c <= 31) && (c % 2 == 1))
                chk("t2_wr_addr", wr_addr, (c - 1) / 2);
            chk("t2_min_en", min_en, (c == 33));
            chk("t2_valid_out", valid_out, (c >= 34 && c <= 49));
            if (c >= 34 && c <= 49)
                chk("t2_rd_addr", rd_addr, c - 34);
            @(posedge clk); #1;
        end

        // Test 3: four contiguous blocks, full frame
        do_reset();
        for (int c = 0; c < 90; c++) begin
            in_valid = (c < 64);
            @(negedge clk);
            chk("t3_mag_en", mag_en, (c >= 1 && c <= 64));
            if (c >= 1 && c <= 64) begin
                chk("t3_wr_addr", wr_addr, (c - 1) % 16);
                chk("t3_wr_bank", wr_bank, ((c - 1) / 16) % 2);
            end
            chk("t3_min_en", min_en, (c == 18 || c == 34 || c == 50 || c == 66));
            chk("t3_valid_out", valid_out, (c >= 19 && c <= 82));
            if (c >= 19 && c <= 82) begin
                chk("t3_rd_addr", rd_addr, (c - 19) % 16);
                chk("t3_rd_bank", rd_bank, ((c - 19) / 16) % 2);
                chk("t3_blk_idx", blk_idx, (c - 19) / 16);
            end
            chk("t3_frame_done", frame_done, (c == 82));
            chk("t3_overrun", overrun, 0);
            if (c == 85)
                chk("t3_blk_idx_wrap", blk_idx, 0);
            @(posedge clk); #1;
        end

        // Test 4: partial block dropped by reset, then a full block
        do_reset();
        for (int c = 0; c < 50; c++) begin
            rst      = (c == 9);
            in_valid = (c < 8) || (c >= 10 && c < 26);
            @(negedge clk);
            if (c <= 9) begin
                chk("t4_pre_mag_en", mag_en, (c >= 1 && c <= 8));
                if (c >= 1 && c <= 8)
                    chk("t4_pre_wr_addr", wr_addr, c - 1);
                chk("t4_pre_min_en", min_en, 0);
                chk("t4_pre_valid_out", valid_out, 0);
            end else begin
                chk_single("t4", c - 10);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;

`ifdef CU_CBFP_BACKPRESSURE_EN
        // Test 5: readout stalled while three blocks arrive
        do_reset();
        for (int c = 0; c < 56; c++) begin
            in_valid  = (c < 48);
            out_ready = 1'b0;
            @(negedge clk);
            chk("t5_valid_out", valid_out, (c >= 19));
            chk("t5_rd_addr", rd_addr, 0);
            chk("t5_blk_idx", blk_idx, 0);
            chk("t5_frame_done", frame_done, 0);
            chk("t5_overrun", overrun, (c >= 34));
            @(posedge clk); #1;
        end

        // Test 6: out_ready toggling, four blocks spaced 32 cycles apart
        do_reset();
        for (int c = 0; c < 151; c++) begin
            in_valid  = (c < 128) && ((c % 32) < 16);
            out_ready = (c % 2 == 0);
            @(negedge clk);
            chk("t6_min_en", min_en, (c == 18 || c == 50 || c == 82 || c == 114));
            chk("t6_valid_out", valid_out, (c >= 19 && c <= 146));
            if (c >= 19 && c <= 146) begin
                chk("t6_rd_addr", rd_addr, ((c - 19) % 32) / 2);
                chk("t6_rd_bank", rd_bank, ((c - 19) / 32) % 2);
                chk("t6_blk_idx", blk_idx, (c - 19) / 32);
            end
            chk("t6_frame_done", frame_done, (c == 146));
            chk("t6_overrun", overrun, 0);
            @(posedge clk); #1;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
